// File: rtl/neuron_buffer_io_ctrl_pkg.sv
// Shared definitions for the neuron buffer IO controller and the buffer wrapper:
// controller state encoding and bit positions of the packed buffer IO bus.
package neuron_buffer_io_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRdIssue,
        StRdCapture,
        StRdHold,
        StDone
    } state_e;

    // Packed IO bus layout: {ioSelect, ioWrite, ioBankSelect[depth-1:0], ioInput[W-1:0]}
    function automatic int unsigned io_bus_width(input int unsigned w, input int unsigned depth);
        return w + depth + 2;
    endfunction

    function automatic int unsigned io_select_pos(input int unsigned w, input int unsigned depth);
        return w + depth + 1;
    endfunction

    function automatic int unsigned io_write_pos(input int unsigned w, input int unsigned depth);
        return w + depth;
    endfunction

    function automatic int unsigned io_bank_msb(input int unsigned w, input int unsigned depth);
        return w + depth - 1;
    endfunction

endpackage

// File: rtl/buffer_addr_gen.sv
// Maps transfer word index k to a buffer bank (k mod D) and row (base + k/D), row wrapping
// modulo 2^A.
module buffer_addr_gen #(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7,
    parameter int unsigned D     = 1 << depth
) (
    input  logic [A-1:0]       i_base_addr,
    input  logic [A+depth-1:0] i_k,
    output logic [depth-1:0]   o_bank,
    output logic [A-1:0]       o_row
);

    // D is a power of two, so k/D is the upper slice of k
    localparam int unsigned Shift = $clog2(D);

    // Bank from the low index bits; row offset added to base with silent wrap
    always_comb begin
        o_bank = i_k[depth-1:0];
        o_row  = i_base_addr + i_k[A+Shift-1:Shift];
    end

endmodule

// File: rtl/neuron_buffer_io_ctrl.sv
// Moves words between the load/unload streams and the banked neuron buffer.
// Loads write one word per accepted stream beat; unloads issue a one-cycle-latency read,
// capture it into m_data and hold it until the consumer takes it.
module neuron_buffer_io_ctrl
    import neuron_buffer_io_ctrl_pkg::*;
#(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7,
    parameter int unsigned D     = 1 << depth,
    parameter int unsigned W     = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   mode,
    input  logic [A-1:0]           base_addr,
    input  logic [A+depth-1:0]     count,
    output logic                   busy,
    output logic                   done,
    input  logic [W-1:0]           s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [W-1:0]           m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [A-1:0]           address,
    output logic [W+depth+1:0]     ioInputs,
    input  logic [W-1:0]           ioOutputs
);

    localparam int unsigned SelPos  = io_select_pos(W, depth);
    localparam int unsigned WrPos   = io_write_pos(W, depth);
    localparam int unsigned BankMsb = io_bank_msb(W, depth);

    state_e               r_state;
    state_e               w_state_next;
    logic [A+depth-1:0]   r_k;
    logic [A+depth-1:0]   r_count;
    logic [A-1:0]         r_base;
    logic                 r_m_valid;
    logic [W-1:0]         r_m_data;

    logic [A+depth-1:0]   w_k_plus;
    logic                 w_k_inc;
    logic                 w_sel;
    logic                 w_wr;
    logic                 w_s_ready;
    logic [depth-1:0]     w_bank;
    logic [A-1:0]         w_row;

    assign w_k_plus = r_k + 1'b1;

    buffer_addr_gen #(
        .depth (depth),
        .A     (A),
        .D     (D)
    ) u_addr_gen (
        .i_base_addr (r_base),
        .i_k         (r_k),
        .o_bank      (w_bank),
        .o_row       (w_row)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and buffer/stream control decode
    always_comb begin
        w_state_next = r_state;
        w_sel        = 1'b0;
        w_wr         = 1'b0;
        w_s_ready    = 1'b0;
        w_k_inc      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (count == '0) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = mode ? StRdIssue : StLoad;
                    end
                end
            end
            StLoad: begin
                w_sel     = 1'b1;
                w_s_ready = 1'b1;
                w_wr      = s_valid;
                if (s_valid) begin
                    w_k_inc = 1'b1;
                    if (w_k_plus == r_count) begin
                        w_state_next = StDone;
                    end
                end
            end
            StRdIssue: begin
                w_sel        = 1'b1;
                w_state_next = StRdCapture;
            end
            StRdCapture: begin
                w_state_next = StRdHold;
            end
            StRdHold: begin
                if (m_ready) begin
                    w_k_inc      = 1'b1;
                    w_state_next = (w_k_plus == r_count) ? StDone : StRdIssue;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Transfer context, word index and unload output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_k       <= '0;
            r_count   <= '0;
            r_base    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (r_state == StIdle && start) begin
                r_base  <= base_addr;
                r_count <= count;
                r_k     <= '0;
            end else if (w_k_inc) begin
                r_k <= w_k_plus;
            end
            if (r_state == StRdCapture) begin
                r_m_data  <= ioOutputs;
                r_m_valid <= 1'b1;
            end else if (r_state == StRdHold && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // Outputs; address and bank are driven only while the buffer is selected
    always_comb begin
        busy     = (r_state != StIdle) && (r_state != StDone);
        done     = (r_state == StDone);
        s_ready  = w_s_ready;
        m_valid  = r_m_valid;
        m_data   = r_m_data;
        address  = w_sel ? w_row : '0;
        ioInputs = '0;
        ioInputs[SelPos]              = w_sel;
        ioInputs[WrPos]               = w_wr;
        ioInputs[BankMsb -: depth]    = w_sel ? w_bank : '0;
        ioInputs[W-1:0]               = w_wr ? s_data : '0;
    end

endmodule

// File: tb/tb_neuron_buffer_io_ctrl.sv
// Directed bench for neuron_buffer_io_ctrl with a banked buffer model (1-cycle read latency).
`timescale 1ns/1ps
module tb_neuron_buffer_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [6:0]  base_addr;
    logic [8:0]  count;
    logic        busy;
    logic        done;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [6:0]  address;
    logic [19:0] ioInputs;
    logic [15:0] ioOutputs = '0;

    always #5 clk = ~clk;

    neuron_buffer_io_ctrl #(
        .depth (2),
        .A     (7),
        .D     (4),
        .W     (16)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .address   (address),
        .ioInputs  (ioInputs),
        .ioOutputs (ioOutputs)
    );

    // Buffer model: 4 banks x 128 rows
    logic [15:0] mem [4][128];
    always @(posedge clk) begin
        if (ioInputs[19] && ioInputs[18]) mem[ioInputs[17:16]][address] <= ioInputs[15:0];
        if (ioInputs[19] && !ioInputs[18]) ioOutputs <= mem[ioInputs[17:16]][address];
    end

    // Bus monitor
    int          cyc = 0;
    int          sel_cnt = 0;
    int          rd_cnt = 0;
    int          done_cyc = -1;
    logic        addr_x = 1'b0;
    logic [24:0] wr_q [$];
    logic [15:0] rx_data [$];
    int          rx_cyc [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ioInputs[19]) sel_cnt <= sel_cnt + 1;
        if (ioInputs[19] && !ioInputs[18]) rd_cnt <= rd_cnt + 1;
        if (ioInputs[19] && ioInputs[18]) wr_q.push_back({ioInputs[17:16], address, ioInputs[15:0]});
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_cyc.push_back(cyc);
        end
        if (done) done_cyc <= cyc;
        if ($isunknown(address)) addr_x <= 1'b1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_start(input logic m, input logic [6:0] b, input logic [8:0] c);
        start = 1'b1;
        mode = m;
        base_addr = b;
        count = c;
        tick();
        start = 1'b0;
        mode = ~m;
        base_addr = 7'd99;
        count = 9'd3;
    endtask

    logic [6:0]  rows_a  [6] = '{7'd5, 7'd5, 7'd5, 7'd5, 7'd6, 7'd6};
    logic [1:0]  banks_a [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] data_a  [6] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006};
    logic [6:0]  rows_d  [8] = '{7'd127, 7'd127, 7'd127, 7'd127, 7'd0, 7'd0, 7'd0, 7'd0};
    logic [1:0]  banks_d [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          rd0;
        int          sel0;
        logic [15:0] d;
        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; count = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_address", {25'd0, address}, 32'd0);
        check("rst_io", {12'd0, ioInputs}, 32'd0);
        rst = 1'b0;
        tick();

        // Load base 5, count 6; one idle beat first, mid-transfer input changes ignored
        pulse_start(1'b0, 7'd5, 9'd6);
        check("ld_busy", {31'd0, busy}, 32'd1);
        check("ld_s_ready", {31'd0, s_ready}, 32'd1);
        check("ld_idle_selwr", {30'd0, ioInputs[19:18]}, 32'd2);
        tick();
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data = data_a[i];
            #1;
            check("ld_addr", {25'd0, address}, {25'd0, rows_a[i]});
            check("ld_io", {12'd0, ioInputs}, {12'd0, 1'b1, 1'b1, banks_a[i], data_a[i]});
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("ld_done", {31'd0, done}, 32'd1);
        check("ld_done_busy", {31'd0, busy}, 32'd0);
        check("ld_done_s_ready", {31'd0, s_ready}, 32'd0);
        check("ld_done_sel", {31'd0, ioInputs[19]}, 32'd0);
        tick();
        check("ld_done_pulse", {31'd0, done}, 32'd0);

        // Unload with m_ready held high: ordered data, 3 cycles apart
        m_ready = 1'b1;
        rx_data.delete();
        rx_cyc.delete();
        pulse_start(1'b1, 7'd5, 9'd6);
        wait_done("ul_done", 60);
        tick();
        check("ul_count", rx_data.size(), 32'd6);
        if (rx_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("ul_data", {16'd0, rx_data[i]}, {16'd0, data_a[i]});
                if (i > 0) check("ul_spacing", rx_cyc[i] - rx_cyc[i-1], 32'd3);
            end
            check("ul_done_cyc", done_cyc, rx_cyc[5] + 1);
        end
        m_ready = 1'b0;

        // Unload with a 4-cycle stall on word 2
        pulse_start(1'b1, 7'd5, 9'd6);
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!m_valid && n < 20) begin
                tick();
                n++;
            end
            check("st_valid", {31'd0, m_valid}, 32'd1);
            check("st_data", {16'd0, m_data}, {16'd0, data_a[i]});
            if (i == 1) begin
                rd0 = rd_cnt;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check("st_hold_valid", {31'd0, m_valid}, 32'd1);
                    check("st_hold_data", {16'd0, m_data}, 32'h1002);
                end
                check("st_no_reads", rd_cnt, rd0);
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        wait_done("st_done", 5);
        tick();

        // Load with row wrap: base 127, count 8
        wr_q.delete();
        pulse_start(1'b0, 7'd127, 9'd8);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data = 16'h2000 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_count", wr_q.size(), 32'd8);
        if (wr_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                d = 16'h2000 + 16'(i);
                check("wr_entry", {7'd0, wr_q[i]}, {7'd0, banks_d[i], rows_d[i], d});
            end
        end
        check("wr_addr_x", {31'd0, addr_x}, 32'd0);
        tick();

        // count = 0: straight to done, buffer never selected
        sel0 = sel_cnt;
        pulse_start(1'b0, 7'd3, 9'd0);
        check("z_done", {31'd0, done}, 32'd1);
        check("z_busy", {31'd0, busy}, 32'd0);
        tick();
        check("z_done_pulse", {31'd0, done}, 32'd0);
        check("z_no_sel", sel_cnt, sel0);

        // start while busy is ignored
        wr_q.delete();
        pulse_start(1'b0, 7'd40, 9'd2);
        pulse_start(1'b1, 7'd99, 9'd0);
        check("bz_busy", {31'd0, busy}, 32'd1);
        check("bz_done", {31'd0, done}, 32'd0);
        s_valid = 1'b1;
        s_data = 16'h3000;
        tick();
        s_data = 16'h3001;
        tick();
        s_valid = 1'b0;
        check("bz_fin", {31'd0, done}, 32'd1);
        check("bz_count", wr_q.size(), 32'd2);
        if (wr_q.size() == 2) begin
            check("bz_w0", {7'd0, wr_q[0]}, {7'd0, 2'd0, 7'd40, 16'h3000});
            check("bz_w1", {7'd0, wr_q[1]}, {7'd0, 2'd1, 7'd40, 16'h3001});
        end
        tick();

        // Reset abort after the 3rd load word, then a fresh transfer
        pulse_start(1'b0, 7'd10, 9'd6);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = 16'h4000 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        check("ab_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_done", {31'd0, done}, 32'd0);
        check("ab_s_ready", {31'd0, s_ready}, 32'd0);
        check("ab_m_valid", {31'd0, m_valid}, 32'd0);
        check("ab_m_data", {16'd0, m_data}, 32'd0);
        check("ab_address", {25'd0, address}, 32'd0);
        check("ab_io", {12'd0, ioInputs}, 32'd0);
        rst = 1'b0;
        tick();
        wr_q.delete();
        pulse_start(1'b0, 7'd20, 9'd1);
        check("ab_restart", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data = 16'h5000;
        tick();
        s_valid = 1'b0;
        check("ab_restart_done", {31'd0, done}, 32'd1);
        check("ab_restart_wr", wr_q.size(), 32'd1);
        if (wr_q.size() == 1) check("ab_restart_w0", {7'd0, wr_q[0]}, {7'd0, 2'd0, 7'd20, 16'h5000});
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
